// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZCV flag bit positions and
// the decode-stage control word carried through the pipeline.
package cpu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       flags_write;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/decode_execute_reg_cond_check.sv
// Combinational evaluation of an instruction condition field against NZCV.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register with the architectural NZCV flags register and
// condition-gated write enables for the downstream stages.
module decode_execute_reg
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RADDR = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             reg_write_d,
    input  logic             mem_to_reg_d,
    input  logic             mem_write_d,
    input  logic             alu_src_d,
    input  logic             flags_write_d,
    input  logic [2:0]       alu_control_d,
    input  logic [3:0]       cond_d,
    input  logic [WIDTH-1:0] rd1_d,
    input  logic [WIDTH-1:0] rd2_d,
    input  logic [WIDTH-1:0] ext_imm_d,
    input  logic [RADDR-1:0] wa3_d,
    input  logic [3:0]       alu_flags_e,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             mem_to_reg_e,
    output logic             alu_src_e,
    output logic [2:0]       alu_control_e,
    output logic [WIDTH-1:0] rd1_e,
    output logic [WIDTH-1:0] rd2_e,
    output logic [WIDTH-1:0] ext_imm_e,
    output logic [RADDR-1:0] wa3_e,
    output logic             cond_ex_e,
    output logic [3:0]       flags_q
);

    ctrl_t            w_ctrl_d;
    ctrl_t            r_ctrl;
    logic [3:0]       r_cond;
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic [WIDTH-1:0] r_ext_imm;
    logic [RADDR-1:0] r_wa3;
    logic [3:0]       r_flags;
    logic             w_cond_ex;
    logic             w_flags_en;

    assign w_ctrl_d = '{
        reg_write:   reg_write_d,
        mem_to_reg:  mem_to_reg_d,
        mem_write:   mem_write_d,
        alu_src:     alu_src_d,
        flags_write: flags_write_d,
        alu_control: alu_control_d
    };

    // Data latches follow the stall alone; a flush only has to kill control.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl    <= CTRL_BUBBLE;
            r_cond    <= COND_AL;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_ext_imm <= '0;
            r_wa3     <= '0;
        end else begin
            if (flush_e) begin
                r_ctrl <= CTRL_BUBBLE;
                r_cond <= COND_AL;
            end else if (!stall_e) begin
                r_ctrl <= w_ctrl_d;
                r_cond <= cond_d;
            end
            if (!stall_e) begin
                r_rd1     <= rd1_d;
                r_rd2     <= rd2_d;
                r_ext_imm <= ext_imm_d;
                r_wa3     <= wa3_d;
            end
        end
    end

    cond_check u_cond_check (
        .i_cond    (r_cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    // An unknown flags_write from an unimplemented opcode only matters when
    // the condition passes; a failed condition forces the enable low.
    assign w_flags_en = r_ctrl.flags_write & w_cond_ex & ~stall_e;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_flags_en) begin
            r_flags <= alu_flags_e;
        end
    end

    assign reg_write_e   = r_ctrl.reg_write & w_cond_ex;
    assign mem_write_e   = r_ctrl.mem_write & w_cond_ex;
    assign mem_to_reg_e  = r_ctrl.mem_to_reg;
    assign alu_src_e     = r_ctrl.alu_src;
    assign alu_control_e = r_ctrl.alu_control;
    assign rd1_e         = r_rd1;
    assign rd2_e         = r_rd2;
    assign ext_imm_e     = r_ext_imm;
    assign wa3_e         = r_wa3;
    assign cond_ex_e     = w_cond_ex;
    assign flags_q       = r_flags;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for the ID/EX register: reset, flag forwarding to the next
// instruction, stall/flush behaviour, full condition table and gated writes.
module tb_decode_execute_reg;

    localparam int WIDTH = 32;
    localparam int RADDR = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall_e;
    logic             flush_e;
    logic             reg_write_d;
    logic             mem_to_reg_d;
    logic             mem_write_d;
    logic             alu_src_d;
    logic             flags_write_d;
    logic [2:0]       alu_control_d;
    logic [3:0]       cond_d;
    logic [WIDTH-1:0] rd1_d;
    logic [WIDTH-1:0] rd2_d;
    logic [WIDTH-1:0] ext_imm_d;
    logic [RADDR-1:0] wa3_d;
    logic [3:0]       alu_flags_e;
    logic             reg_write_e;
    logic             mem_write_e;
    logic             mem_to_reg_e;
    logic             alu_src_e;
    logic [2:0]       alu_control_e;
    logic [WIDTH-1:0] rd1_e;
    logic [WIDTH-1:0] rd2_e;
    logic [WIDTH-1:0] ext_imm_e;
    logic [RADDR-1:0] wa3_e;
    logic             cond_ex_e;
    logic [3:0]       flags_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_execute_reg #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_e       (stall_e),
        .flush_e       (flush_e),
        .reg_write_d   (reg_write_d),
        .mem_to_reg_d  (mem_to_reg_d),
        .mem_write_d   (mem_write_d),
        .alu_src_d     (alu_src_d),
        .flags_write_d (flags_write_d),
        .alu_control_d (alu_control_d),
        .cond_d        (cond_d),
        .rd1_d         (rd1_d),
        .rd2_d         (rd2_d),
        .ext_imm_d     (ext_imm_d),
        .wa3_d         (wa3_d),
        .alu_flags_e   (alu_flags_e),
        .reg_write_e   (reg_write_e),
        .mem_write_e   (mem_write_e),
        .mem_to_reg_e  (mem_to_reg_e),
        .alu_src_e     (alu_src_e),
        .alu_control_e (alu_control_e),
        .rd1_e         (rd1_e),
        .rd2_e         (rd2_e),
        .ext_imm_e     (ext_imm_e),
        .wa3_e         (wa3_e),
        .cond_ex_e     (cond_ex_e),
        .flags_q       (flags_q)
    );

    // Reference condition table, flags ordered N,Z,C,V from bit 3 down.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: ref_cond = z;
            4'h1: ref_cond = !z;
            4'h2: ref_cond = cf;
            4'h3: ref_cond = !cf;
            4'h4: ref_cond = n;
            4'h5: ref_cond = !n;
            4'h6: ref_cond = v;
            4'h7: ref_cond = !v;
            4'h8: ref_cond = cf && !z;
            4'h9: ref_cond = !cf || z;
            4'hA: ref_cond = (n == v);
            4'hB: ref_cond = (n != v);
            4'hC: ref_cond = !z && (n == v);
            4'hD: ref_cond = z || (n != v);
            4'hE: ref_cond = 1'b1;
            default: ref_cond = 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        stall_e       = 1'b0;
        flush_e       = 1'b0;
        reg_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
        mem_write_d   = 1'b0;
        alu_src_d     = 1'b0;
        flags_write_d = 1'b0;
        alu_control_d = 3'b000;
        cond_d        = 4'b1110;
        rd1_d         = '0;
        rd2_d         = '0;
        ext_imm_d     = '0;
        wa3_d         = '0;
        alu_flags_e   = 4'b0000;
    endtask

    // Flag-setting AL instruction enters E, ALU reports f, flags land next edge.
    task automatic load_flags(input logic [3:0] f);
        drive_nop();
        flags_write_d = 1'b1;
        tick();
        drive_nop();
        alu_flags_e = f;
        tick();
        alu_flags_e = 4'b0000;
    endtask

    task automatic test_reset();
        drive_nop();
        rst_n         = 1'b0;
        flags_write_d = 1'b1;
        reg_write_d   = 1'b1;
        mem_write_d   = 1'b1;
        mem_to_reg_d  = 1'b1;
        alu_src_d     = 1'b1;
        alu_control_d = 3'($urandom_range(0, 7));
        cond_d        = 4'($urandom_range(0, 15));
        rd1_d         = $urandom;
        rd2_d         = $urandom;
        ext_imm_d     = $urandom;
        wa3_d         = 4'($urandom_range(1, 15));
        alu_flags_e   = 4'b1111;
        tick();
        tick();
        total++;
        if ({reg_write_e, mem_write_e, mem_to_reg_e, alu_src_e, alu_control_e} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0", {reg_write_e, mem_write_e, mem_to_reg_e, alu_src_e, alu_control_e});
        end
        total++;
        if ({rd1_e, rd2_e, ext_imm_e, wa3_e} !== '0) begin
            bad++;
            $display("FAIL reset_data rd1=%h rd2=%h imm=%h wa3=%h exp=0", rd1_e, rd2_e, ext_imm_e, wa3_e);
        end
        total++;
        if (flags_q !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000", flags_q);
        end
        total++;
        if (cond_ex_e !== 1'b1) begin
            bad++;
            $display("FAIL reset_cond_ex got=%b exp=1", cond_ex_e);
        end
        rst_n = 1'b1;
        drive_nop();
        tick();
    endtask

    task automatic test_datapath();
        drive_nop();
        rd1_d         = 32'h1234_5678;
        rd2_d         = 32'hCAFE_F00D;
        ext_imm_d     = 32'h0000_00FF;
        wa3_d         = 4'hA;
        mem_to_reg_d  = 1'b1;
        alu_src_d     = 1'b1;
        alu_control_d = 3'b110;
        tick();
        total++;
        if ({rd1_e, rd2_e, ext_imm_e, wa3_e} !== {32'h1234_5678, 32'hCAFE_F00D, 32'h0000_00FF, 4'hA}) begin
            bad++;
            $display("FAIL datapath rd1=%h rd2=%h imm=%h wa3=%h exp=12345678/cafef00d/000000ff/a", rd1_e, rd2_e, ext_imm_e, wa3_e);
        end
        total++;
        if ({mem_to_reg_e, alu_src_e, alu_control_e} !== 5'b11110) begin
            bad++;
            $display("FAIL datapath_ctrl got=%b exp=11110", {mem_to_reg_e, alu_src_e, alu_control_e});
        end
    endtask

    task automatic test_cmp_beq();
        load_flags(4'b0100);
        total++;
        if (flags_q !== 4'b0100) begin
            bad++;
            $display("FAIL cmp_flags got=%b exp=0100", flags_q);
        end
        drive_nop();
        cond_d      = 4'b0000;
        reg_write_d = 1'b1;
        tick();
        total++;
        if (reg_write_e !== 1'b1) begin
            bad++;
            $display("FAIL beq_taken reg_write_e got=%b exp=1", reg_write_e);
        end
        cond_d = 4'b0001;
        tick();
        total++;
        if (reg_write_e !== 1'b0) begin
            bad++;
            $display("FAIL bne_skipped reg_write_e got=%b exp=0", reg_write_e);
        end
    endtask

    // Flags are 0100 on entry.
    task automatic test_stall();
        drive_nop();
        rd1_d         = 32'hDEAD_BEEF;
        flags_write_d = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            stall_e       = 1'b1;
            rd1_d         = $urandom;
            flags_write_d = 1'b0;
            reg_write_d   = 1'b1;
            alu_flags_e   = 4'b1111;
            tick();
            total++;
            if (rd1_e !== 32'hDEAD_BEEF) begin
                bad++;
                $display("FAIL stall_hold_rd1 cyc=%0d got=%h exp=deadbeef", i, rd1_e);
            end
            total++;
            if (flags_q !== 4'b0100) begin
                bad++;
                $display("FAIL stall_flags cyc=%0d got=%b exp=0100", i, flags_q);
            end
        end
        drive_nop();
        alu_flags_e = 4'b0010;
        tick();
        total++;
        if (flags_q !== 4'b0010) begin
            bad++;
            $display("FAIL stall_release_flags got=%b exp=0010", flags_q);
        end
    endtask

    // Flags are 0010 on entry.
    task automatic test_flush_vs_stall();
        drive_nop();
        stall_e       = 1'b1;
        flush_e       = 1'b1;
        reg_write_d   = 1'b1;
        mem_write_d   = 1'b1;
        mem_to_reg_d  = 1'b1;
        flags_write_d = 1'b1;
        alu_control_d = 3'b111;
        cond_d        = 4'b0000;
        alu_flags_e   = 4'b1111;
        tick();
        total++;
        if ({reg_write_e, mem_write_e, cond_ex_e} !== 3'b001) begin
            bad++;
            $display("FAIL flush_ctrl rw/mw/cx got=%b exp=001", {reg_write_e, mem_write_e, cond_ex_e});
        end
        total++;
        if ({mem_to_reg_e, alu_control_e} !== 4'b0000) begin
            bad++;
            $display("FAIL flush_ungated got=%b exp=0000", {mem_to_reg_e, alu_control_e});
        end
        total++;
        if (flags_q !== 4'b0010) begin
            bad++;
            $display("FAIL flush_flags got=%b exp=0010", flags_q);
        end
        drive_nop();
        alu_flags_e = 4'b1111;
        tick();
        total++;
        if (flags_q !== 4'b0010) begin
            bad++;
            $display("FAIL bubble_no_flag_update got=%b exp=0010", flags_q);
        end
    endtask

    task automatic test_cond_sweep();
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            total++;
            if (flags_q !== 4'(f)) begin
                bad++;
                $display("FAIL sweep_preload got=%b exp=%b", flags_q, 4'(f));
            end
            for (int c = 0; c < 16; c++) begin
                drive_nop();
                cond_d      = 4'(c);
                reg_write_d = 1'b1;
                tick();
                total++;
                if (cond_ex_e !== ref_cond(4'(c), 4'(f))) begin
                    bad++;
                    $display("FAIL sweep_cond cond=%h flags=%b got=%b exp=%b", c, 4'(f), cond_ex_e, ref_cond(4'(c), 4'(f)));
                end
                total++;
                if (reg_write_e !== ref_cond(4'(c), 4'(f))) begin
                    bad++;
                    $display("FAIL sweep_reg_write cond=%h flags=%b got=%b exp=%b", c, 4'(f), reg_write_e, ref_cond(4'(c), 4'(f)));
                end
            end
        end
    endtask

    task automatic test_failed_cond();
        load_flags(4'b0000);
        drive_nop();
        cond_d        = 4'b0000;
        mem_write_d   = 1'b1;
        mem_to_reg_d  = 1'b1;
        alu_src_d     = 1'b1;
        alu_control_d = 3'b101;
        tick();
        total++;
        if ({mem_write_e, cond_ex_e} !== 2'b00) begin
            bad++;
            $display("FAIL str_eq_skipped mw/cx got=%b exp=00", {mem_write_e, cond_ex_e});
        end
        total++;
        if ({mem_to_reg_e, alu_src_e, alu_control_e} !== 5'b11101) begin
            bad++;
            $display("FAIL str_ungated got=%b exp=11101", {mem_to_reg_e, alu_src_e, alu_control_e});
        end
        drive_nop();
        cond_d        = 4'b0000;
        flags_write_d = 1'b1;
        tick();
        drive_nop();
        alu_flags_e = 4'b1111;
        tick();
        total++;
        if (flags_q !== 4'b0000) begin
            bad++;
            $display("FAIL cmp_eq_skipped got=%b exp=0000", flags_q);
        end
        drive_nop();
        cond_d        = 4'b0001;
        flags_write_d = 1'b1;
        mem_write_d   = 1'b1;
        tick();
        total++;
        if (mem_write_e !== 1'b1) begin
            bad++;
            $display("FAIL str_ne_taken got=%b exp=1", mem_write_e);
        end
        drive_nop();
        alu_flags_e = 4'b1001;
        tick();
        total++;
        if (flags_q !== 4'b1001) begin
            bad++;
            $display("FAIL cmp_ne_taken got=%b exp=1001", flags_q);
        end
    endtask

    // Unknown controls from an unimplemented opcode under a never condition.
    task automatic test_x_controls();
        drive_nop();
        cond_d        = 4'b1111;
        flags_write_d = 1'bx;
        reg_write_d   = 1'bx;
        mem_write_d   = 1'bx;
        tick();
        drive_nop();
        alu_flags_e = 4'b0110;
        total++;
        if ({reg_write_e, mem_write_e, cond_ex_e} !== 3'b000) begin
            bad++;
            $display("FAIL x_ctrl_gated got=%b exp=000", {reg_write_e, mem_write_e, cond_ex_e});
        end
        tick();
        total++;
        if (flags_q !== 4'b1001) begin
            bad++;
            $display("FAIL x_flags_hold got=%b exp=1001", flags_q);
        end
    endtask

    initial begin
        drive_nop();
        rst_n = 1'b0;
        test_reset();
        test_datapath();
        test_cmp_beq();
        test_stall();
        test_flush_vs_stall();
        test_cond_sweep();
        test_failed_cond();
        test_x_controls();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- ID/EX pipeline boundary of the pipelined CPU.
- Latches the decode-stage control word (from the instruction decoder) together with the register-file operands, extended immediate and destination address.
- Owns the architectural NZCV flags register and evaluates the instruction condition field in execute.
- Drives condition-gated write enables to the execute, memory and writeback stages.

Parameters:
- WIDTH, 32, datapath width of operands and immediate.
- RADDR, 4, register address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- stall_e  in  1  hold ID/EX contents.
- flush_e  in  1  load a bubble into ID/EX.
- reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, flags_write_d  in  1 each  decoder control outputs.
- alu_control_d  in  3  ALU operation from decoder.
- cond_d  in  4  instruction condition field [31:28].
- rd1_d, rd2_d, ext_imm_d  in  WIDTH each  register operands, extended immediate.
- wa3_d  in  RADDR  destination register.
- alu_flags_e  in  4  NZCV produced by the ALU this cycle.
- reg_write_e, mem_write_e, mem_to_reg_e, alu_src_e  out  1 each  registered control; reg_write_e and mem_write_e are gated by cond_ex_e.
- alu_control_e  out  3  registered ALU op.
- rd1_e, rd2_e, ext_imm_e  out  WIDTH each  registered data.
- wa3_e  out  RADDR  registered destination.
- cond_ex_e  out  1  condition passed for the instruction in E.
- flags_q  out  4  current NZCV register (N=bit3, Z=2, C=1, V=0).

Behaviour:
- Reset (rst_n=0 at clk edge): all latched control = 0; data = 0; wa3 = 0; cond latch = 4'b1110 (AL); flags_q = 4'b0000. Reset overrides stall and flush.
- Latency: 1 cycle D→E for all fields. Gated outputs are combinational from latched fields plus flags_q.
- Priority per edge: reset > flush_e > stall_e > normal load.
- flush_e=1: all control latches = 0, cond = AL. Data latches may load or hold; verification treats them as don't-care after a flush.
- stall_e=1 (flush_e=0): every latch holds its value.
- Flags update:
  - flags_q <= alu_flags_e when flags_write_latched & cond_ex_e & !stall_e.
  - Otherwise flags_q holds.
  - An update is visible to the next instruction's condition check on the following cycle; no same-cycle bypass.
- Condition evaluation on latched cond against flags_q:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (never; treated as NOP)
- reg_write_e = reg_write_latched & cond_ex_e; mem_write_e = mem_write_latched & cond_ex_e.
- mem_to_reg_e, alu_src_e, alu_control_e are passed ungated.
- A bubble yields reg_write_e = mem_write_e = 0 and no flags update.
- Don't-care (x) controls from the decoder for unimplemented opcodes are captured as-is. They must never reach the flags register: flags_write x is sampled only through the gated AND.

Decomposition:
- Shared package cpu_pkg:
  - cond_e enum (EQ..AL, NV) as 4-bit constants.
  - Flag bit index constants (FLAG_N/Z/C/V).
  - Control-word packed struct {reg_write, mem_to_reg, mem_write, alu_src, flags_write, alu_control[2:0]}.
- One sub-module, cond_check: combinational cond + NZCV → cond_ex, instantiated once.
- Pipeline register and flags register live in the top.

Test Plan:
- Reset: hold rst_n=0 two cycles with random D inputs and flags_write_d=1 → all E outputs 0, flags_q=0000, cond_ex_e=1 (AL).
- CMP then BEQ-style conditional ADD:
  - Load flags_write_d=1, cond_d=AL, drive alu_flags_e=0100 in E → flags_q=0100 next cycle.
  - Following instr cond_d=0000, reg_write_d=1 → reg_write_e=1.
  - Repeat with cond_d=0001 → reg_write_e=0.
- Stall: load rd1_d=32'hDEAD_BEEF, then stall_e=1 for 3 cycles while D inputs change → rd1_e stays DEAD_BEEF. With flags_write latched, flags_q does not change during the stall.
- Flush vs stall: assert both with reg_write_d=1, mem_write_d=1 → next cycle reg_write_e=0, mem_write_e=0, cond_ex_e=1; flags unchanged.
- Condition sweep: for each of 16 conds × all 16 flag values (preload via AL flag-writing instruction) → cond_ex_e matches the table. Cond 1111 is always 0; GE/LT checked at N=1,V=1 and N=1,V=0.
- Failed-condition store: flags Z=0, STR with cond EQ (mem_write_d=1) → mem_write_e=0. Conditional CMP with failed cond → flags_q unchanged.
